imm_encoder: RTL and testbench

//  Inverse of the immediate extender: packs a signed 32-bit immediate into the I/S/B

---
 rtl/imm_encoder.sv | 170 +++++++++++++++++
 tb/tb_imm_encoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed 32-bit immediate into the I/S/B immediate fields
// of an instruction template and flags immediates the format cannot represent.
// Structure: combinational encode/check -> S1 register -> circular output FIFO.
// The FIFO head drives Instr/out_err. Saturating counters track popped results.
module imm_encoder #(
  parameter int FIFO_DEPTH = 3,  // minimum 3 for one result per cycle
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_W  = (OCC_W + 1)'(FIFO_DEPTH);

  // Bits of the template that survive for each format; the remaining bits
  // are the immediate fields and are overwritten by the encoder.
  localparam logic [31:0] KEEP_I  = 32'h000F_FFFF;
  localparam logic [31:0] KEEP_SB = 32'h01FF_F07F;

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

  // Range-check helpers: the upper slice must be pure sign extension.
  logic fits_12;  // Imm[31:11] all equal
  logic fits_13;  // Imm[31:12] all equal

  entry_t enc;
  logic   accept;

  logic   s1_valid;
  entry_t s1_entry;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   count;
  logic [OCC_W:0]     occupancy;
  logic               push;
  logic               pop;
  entry_t             head;

  assign fits_12 = (&Imm[31:11]) | ~(|Imm[31:11]);
  assign fits_13 = (&Imm[31:12]) | ~(|Imm[31:12]);

  // Encode the immediate into the template and run the range check.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    enc = '{instr: Base, err: 1'b0};
    case (fmt_e'(ImmSrc))
      FMT_I: begin
        enc.instr         = Base & KEEP_I;
        enc.instr[31:20]  = Imm[11:0];
        enc.err           = ~fits_12;
      end
      FMT_S: begin
        enc.instr         = Base & KEEP_SB;
        enc.instr[31:25]  = Imm[11:5];
        enc.instr[11:7]   = Imm[4:0];
        enc.err           = ~fits_12;
      end
      FMT_B: begin
        enc.instr         = Base & KEEP_SB;
        enc.instr[31]     = Imm[12];
        enc.instr[7]      = Imm[11];
        enc.instr[30:25]  = Imm[10:5];
        enc.instr[11:8]   = Imm[4:1];
        enc.err           = ~fits_13 | Imm[0];
      end
      default: begin
        // Invalid selector: template passes through untouched, flagged.
        enc.instr = Base;
        enc.err   = 1'b1;
      end
    endcase
  end

  // Space is reserved for the S1 entry too, so the ready decision depends on
  // registers only and never on out_ready.
  assign occupancy = {1'b0, count} + {{OCC_W{1'b0}}, s1_valid};
  assign in_ready  = occupancy < DEPTH_W;
  assign accept    = in_valid & in_ready;

  // S1 valid bit: set by an accept, otherwise drains into the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= accept;
  end

  // S1 payload: loads only on a handshake, so inputs are sampled nowhere else.
  always_ff @(posedge clk) begin
    if (accept) s1_entry <= enc;
  end

  assign push = s1_valid;
  assign pop  = out_valid & out_ready;

  // FIFO storage: the S1 entry lands here on the edge after it was accepted.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers and count are reset, and
    // the output mux forces zeros while the FIFO is empty.
    if (push) mem[wr_ptr] <= s1_entry;
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign Instr     = out_valid ? head.instr : 32'h0;
  assign out_err   = out_valid ? head.err   : 1'b0;

  // Statistics: classify each popped entry and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (pop) begin
      if (head.err) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end else begin
        if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // The ready rule must never let S1 write into a full FIFO.
  push_into_full : assert property (@(posedge clk) disable iff (rst)
    push |-> (count < DEPTH_C));
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: fixed vector table, hand-written pipeline/backpressure
// and reset sequences, then randomized traffic scored against a reference
// model of the encoding rules and a decode-back (extender) round-trip.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm;
  logic [31:0] Base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  // Narrow-counter twin, fed identically, used to see saturation.
  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] instr_s;
  logic        out_err_s;
  logic [2:0]  enc_count_s;
  logic [2:0]  err_count_s;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .Imm(Imm), .Base(Base), .out_valid(out_valid),
    .out_ready(out_ready), .Instr(Instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  imm_encoder #(.FIFO_DEPTH(3), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .ImmSrc(ImmSrc), .Imm(Imm), .Base(Base), .out_valid(out_valid_s),
    .out_ready(out_ready), .Instr(instr_s), .out_err(out_err_s),
    .enc_count(enc_count_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_pops = 0;
  int   exp_enc = 0;
  int   exp_errc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference encoder written from the field rules with masks and shifts.
  function automatic void ref_encode(input logic [1:0] src, input logic [31:0] imm,
                                     input logic [31:0] base,
                                     output logic [31:0] instr, output logic err);
    int signed v;
    v = $signed(imm);
    case (src)
      2'b00: begin
        instr = (base & 32'h000F_FFFF) | (imm << 20);
        err   = (v < -2048) || (v > 2047);
      end
      2'b01: begin
        instr = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25)
              | ((imm & 32'h1F) << 7);
        err   = (v < -2048) || (v > 2047);
      end
      2'b10: begin
        instr = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
              | (((imm >> 11) & 32'h1) << 7) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8);
        err   = (v < -4096) || (v > 4095) || ((imm & 32'h1) != 0);
      end
      default: begin
        instr = base;
        err   = 1'b1;
      end
    endcase
  endfunction

  // Immediate extender: what the decoder would recover from an instruction.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [1:0] src);
    case (src)
      2'b00:   return 32'($signed(i) >>> 20);
      2'b01:   return (32'($signed(i) >>> 25) << 5) | ((i >> 7) & 32'h1F);
      default: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endcase
  endfunction

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL spurious_output: got Instr %h with no request outstanding", Instr);
    end else begin
      e = q.pop_front();
      check("instr", Instr, e.instr);
      check("out_err", 32'(out_err), 32'(e.err));
      if (!e.err && e.src != 2'b11) check("roundtrip", extend(Instr, e.src), e.imm);
      if (e.err) exp_errc++;
      else       exp_enc++;
      n_pops++;
    end
  endtask

  // One clock cycle: drive inputs, note handshakes against the scoreboard,
  // then advance to 1 ns after the next rising edge.
  task automatic step(input logic v, input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] e_instr,
                      input logic e_err, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = v;
    ImmSrc    = src;
    Imm       = imm;
    Base      = base;
    out_ready = ordy;
    acc = v && in_ready;
    if (acc) begin
      e.src = src; e.imm = imm; e.instr = e_instr; e.err = e_err;
      q.push_back(e);
    end
    if (out_valid && ordy) pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, ordy, a);
  endtask

  task automatic drain();
    for (int c = 0; c < 20; c++) begin
      if (q.size() == 0 && !out_valid) break;
      idle(1'b1);
    end
    check("drain_left", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic send(input logic [1:0] src, input logic [31:0] imm,
                      input logic [31:0] base, input logic ordy, output logic acc);
    logic [31:0] ei;
    logic        ee;
    ref_encode(src, imm, base, ei, ee);
    step(1'b1, src, imm, base, ei, ee, ordy, acc);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_enc_count"}, 32'(enc_count), 32'(exp_enc));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_errc));
    check({tag, "_sat_enc"}, 32'(enc_count_s), 32'((exp_enc > 7) ? 7 : exp_enc));
    check({tag, "_sat_err"}, 32'(err_count_s), 32'((exp_errc > 7) ? 7 : exp_errc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [12];
    logic        a;
    int          ptr;
    int          pops0;
    vec_t        req [5];
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] ei;
    logic        ee;

    // {src, imm, base, expected instr, expected err}
    tbl[0]  = '{2'b01, 32'h0000_007F, 32'h0000_2023, 32'h0600_2FA3, 1'b0};
    tbl[1]  = '{2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    tbl[2]  = '{2'b10, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
    tbl[3]  = '{2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    tbl[4]  = '{2'b11, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    tbl[5]  = '{2'b00, 32'h0000_07FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    tbl[6]  = '{2'b00, 32'hFFFF_F7FF, 32'h0000_0000, 32'h7FF0_0000, 1'b1};
    tbl[7]  = '{2'b01, 32'hFFFF_F800, 32'hFFFF_FFFF, 32'h81FF_F07F, 1'b0};
    tbl[8]  = '{2'b10, 32'h0000_0FFE, 32'h0000_0000, 32'h7E00_0F80, 1'b0};
    tbl[9]  = '{2'b10, 32'h0000_1000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[10] = '{2'b10, 32'hFFFF_F000, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[11] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFE00_0F80, 1'b0};

    // Reset state.
    rst = 1'b1; in_valid = 1'b0; ImmSrc = 2'b00; Imm = '0; Base = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_instr", Instr, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check_counters("rst");

    // Latency: request cycle, S1 cycle, then the result is at the FIFO head.
    step(1'b1, 2'b00, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b0, a);
    check("lat_accept", 32'(a), 32'd1);
    check("lat_s1_not_visible", 32'(out_valid), 32'd0);
    idle(1'b0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    check("lat_popped", 32'(out_valid), 32'd0);

    // Table vectors, streamed with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].src, tbl[i].imm, tbl[i].base, tbl[i].instr, tbl[i].err, 1'b1, a);
      check("tbl_accept", 32'(a), 32'd1);
      if (i == 4) begin
        drain();
        check_counters("tbl_mid");
      end
    end
    drain();
    check_counters("tbl");

    // Backpressure: five back-to-back requests with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      req[i].src  = 2'(i % 3);
      req[i].imm  = 32'(i * 8 - 16);
      req[i].base = 32'h0000_0013 + 32'(i << 12);
    end
    ptr = 0;
    for (int c = 0; c < 5; c++) begin
      send(req[ptr].src, req[ptr].imm, req[ptr].base, 1'b0, a);
      if (a) ptr++;
    end
    check("bp_accepted", 32'(ptr), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", Instr, q[0].instr);
    idle(1'b0);
    check("bp_head_stable", Instr, q[0].instr);
    check("bp_out_valid_held", 32'(out_valid), 32'd1);
    pops0 = n_pops;
    for (int c = 0; c < 5; c++) begin
      if (ptr < 5) begin
        send(req[ptr].src, req[ptr].imm, req[ptr].base, 1'b1, a);
        if (a) ptr++;
      end else begin
        idle(1'b1);
      end
    end
    check("bp_all_accepted", 32'(ptr), 32'd5);
    check("bp_one_per_cycle", 32'(n_pops - pops0), 32'd5);
    drain();
    check_counters("bp");

    // Reset with two entries in the FIFO and S1 occupied.
    for (int c = 0; c < 3; c++) send(2'b00, 32'(c), 32'h13, 1'b0, a);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_enc = 0;
    exp_errc = 0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_instr", Instr, 32'h0);
    check_counters("midrst");
    idle(1'b1);
    check("midrst_flushed", 32'(out_valid), 32'd0);

    // Randomized traffic with random stalls on both sides.
    for (int n = 0; n < 3000; n++) begin
      src  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($signed($urandom) >>> 19);
        2:       imm = 32'($signed($urandom) >>> 20);
        default: imm = 32'($signed($urandom) >>> 19) & 32'hFFFF_FFFE;
      endcase
      base = $urandom;
      ref_encode(src, imm, base, ei, ee);
      step($urandom_range(0, 3) != 0, src, imm, base, ei, ee,
           $urandom_range(0, 3) != 0, a);
    end
    drain();
    check_counters("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
